// File: rtl/uart_link_sched.sv
// Host-link scheduler: fair sharing of one UART transmitter between a periodic
// drive-command frame and a one-shot request port, plus receive-side supervision.
module uart_link_sched #(
   parameter int unsigned PERIOD_MS     = 2,
   parameter int unsigned TX_TIMEOUT_MS = 5,
   parameter int unsigned RX_TIMEOUT_MS = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [7:0] cmd_data,
   input  logic       req_valid,
   input  logic [7:0] req_data,
   output logic       req_ready,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_done,
   output logic       busy,
   output logic       tx_err,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_err,
   output logic       link_up,
   output logic [3:0] sensor,
   output logic [7:0] bad_cnt
);

   localparam int unsigned PW = $clog2(PERIOD_MS + 1);
   localparam int unsigned TW = $clog2(TX_TIMEOUT_MS + 1);
   localparam int unsigned WW = $clog2(RX_TIMEOUT_MS + 1);

   localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_MS - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TX_TIMEOUT_MS - 1);
   localparam logic [WW-1:0] WD_MAX   = WW'(RX_TIMEOUT_MS);
   localparam logic [WW-1:0] WD_LAST  = WW'(RX_TIMEOUT_MS - 1);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] LOAD      = 2'd1;
   localparam logic [1:0] WAIT_DONE = 2'd2;

   localparam logic SRC_REQ = 1'b0;
   localparam logic SRC_PER = 1'b1;

   logic [1:0]    state;
   logic [PW-1:0] per_cnt;
   logic          per_pend;
   logic          per_set;
   logic          last_grant;
   logic [TW-1:0] to_cnt;
   logic [WW-1:0] wd_cnt;
   logic          grant_per;
   logic          grant_req;
   logic          rx_good;
   logic          rx_bad;
   logic          unused_bits;

   assign unused_bits = ^{cmd_data[7], rx_data[6:4]};

   // Round-robin between the two sources; only arbitrate while idle.
   always_comb begin
      per_set   = tick && (per_cnt == PER_LAST);
      grant_req = 1'b0;
      grant_per = 1'b0;
      if (state == IDLE) begin
         if (per_pend && req_valid) begin
            grant_req = (last_grant == SRC_PER);
            grant_per = (last_grant == SRC_REQ);
         end else begin
            grant_req = req_valid;
            grant_per = per_pend;
         end
      end
   end

   assign req_ready = grant_req;
   assign tx_start  = (state == LOAD);
   assign busy      = (state != IDLE);

   // Period generator; a fresh expiry beats a same-cycle grant clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         per_cnt  <= '0;
         per_pend <= 1'b0;
      end else begin
         if (tick) per_cnt <= per_set ? '0 : per_cnt + 1'b1;
         if (per_set)        per_pend <= 1'b1;
         else if (grant_per) per_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= SRC_PER;
         tx_data    <= '0;
         to_cnt     <= '0;
         tx_err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_req || grant_per) begin
                  state      <= LOAD;
                  last_grant <= grant_per ? SRC_PER : SRC_REQ;
                  tx_data    <= grant_per ? {1'b1, cmd_data[6:0]} : req_data;
               end
            end
            LOAD: begin
               state  <= WAIT_DONE;
               to_cnt <= '0;
            end
            WAIT_DONE: begin
               // Completion takes priority over a coincident timeout.
               if (tx_done) begin
                  state <= IDLE;
               end else if (tick) begin
                  if (to_cnt == TO_LAST) begin
                     tx_err <= 1'b1;
                     state  <= IDLE;
                  end else begin
                     to_cnt <= to_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rx_good = rx_valid && !rx_err && rx_data[7];
   assign rx_bad  = rx_valid && !rx_good;

   // Watchdog expiry forces a safe stop unless a good frame lands that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         sensor  <= '0;
         link_up <= 1'b0;
         wd_cnt  <= '0;
         bad_cnt <= '0;
      end else begin
         if (rx_bad && (bad_cnt != 8'hFF)) bad_cnt <= bad_cnt + 1'b1;
         if (rx_good) begin
            sensor  <= rx_data[3:0];
            link_up <= 1'b1;
            wd_cnt  <= '0;
         end else if (tick && (wd_cnt != WD_MAX)) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == WD_LAST) begin
               link_up <= 1'b0;
               sensor  <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_link_sched.sv
// Directed bench for uart_link_sched; transmitted bytes are checked against a
// scoreboard of expected frames pushed as each grant is provoked.
module tb_uart_link_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       req_valid = 1'b0;
   logic [7:0] req_data = 8'h00;
   logic       req_ready;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_done = 1'b0;
   logic       busy;
   logic       tx_err;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_err = 1'b0;
   logic       link_up;
   logic [3:0] sensor;
   logic [7:0] bad_cnt;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] sb[$];
   logic [7:0] sb_exp;
   logic       auto_per = 1'b0;

   uart_link_sched #(.PERIOD_MS(2), .TX_TIMEOUT_MS(5), .RX_TIMEOUT_MS(100)) dut (
      .clk(clk), .rst(rst), .tick(tick), .cmd_data(cmd_data),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
      .busy(busy), .tx_err(tx_err), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_err(rx_err), .link_up(link_up), .sensor(sensor), .bad_cnt(bad_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_pulse();
      tick = 1'b1;
      clk1();
      tick = 1'b0;
      clk1();
   endtask

   task automatic wait_start(input int budget);
      int i = 0;
      while (!tx_start && i < budget) begin
         clk1();
         i++;
      end
      chk("start_seen", 8'(tx_start), 8'd1);
   endtask

   task automatic send_done();
      tx_done = 1'b1;
      clk1();
      tx_done = 1'b0;
      #1;
      chk("busy_after_done", 8'(busy), 8'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},    8'(busy),     8'd0);
      chk({tag, "_start"},   8'(tx_start), 8'd0);
      chk({tag, "_txdata"},  tx_data,      8'h00);
      chk({tag, "_txerr"},   8'(tx_err),   8'd0);
      chk({tag, "_link"},    8'(link_up),  8'd0);
      chk({tag, "_sensor"},  8'(sensor),   8'd0);
      chk({tag, "_badcnt"},  bad_cnt,      8'd0);
      chk({tag, "_ready"},   8'(req_ready),8'd0);
   endtask

   // Every transmitter start must match the oldest expected frame.
   always @(negedge clk) begin
      if (!rst && tx_start) begin
         if (auto_per) begin
            chk("tx_data_auto", tx_data, {1'b1, cmd_data[6:0]});
         end else begin
            n_tests++;
            assert (sb.size() != 0) else begin
               n_fail++;
               $error("FAIL sb_unexpected_start observed=%0h expected=none", tx_data);
            end
            if (sb.size() != 0) begin
               sb_exp = sb.pop_front();
               chk("tx_data", tx_data, sb_exp);
            end
         end
      end
   end

   initial begin
      // Reset state
      repeat (3) clk1();
      chk_all_zero("reset");
      rst = 1'b0;
      clk1();

      // Periodic frames only
      cmd_data = 8'h05;
      for (int k = 0; k < 3; k++) begin
         sb.push_back(8'h85);
         tick_pulse();
         chk("no_early_start", 8'(tx_start), 8'd0);
         tick_pulse();
         wait_start(6);
         chk("per_ready_low", 8'(req_ready), 8'd0);
         chk("busy_load", 8'(busy), 8'd1);
         clk1();
         chk("busy_wait", 8'(busy), 8'd1);
         clk1();
         send_done();
      end

      // Contention: REQ, PER, REQ
      cmd_data = 8'h42;
      sb.push_back(8'hC2);
      tick_pulse();
      tick_pulse();
      wait_start(6);
      clk1();
      tick_pulse();
      tick_pulse();
      req_valid = 1'b1;
      req_data  = 8'h3C;
      #1;
      chk("ready_while_busy", 8'(req_ready), 8'd0);
      sb.push_back(8'h3C);
      send_done();
      chk("grant1_req_ready", 8'(req_ready), 8'd1);
      clk1();
      wait_start(2);
      sb.push_back(8'hC2);
      clk1();
      send_done();
      chk("grant2_per_ready", 8'(req_ready), 8'd0);
      clk1();
      wait_start(2);
      sb.push_back(8'h3C);
      clk1();
      tick_pulse();
      tick_pulse();
      send_done();
      chk("grant3_req_ready", 8'(req_ready), 8'd1);
      clk1();
      req_valid = 1'b0;
      wait_start(2);
      sb.push_back(8'hC2);
      clk1();
      send_done();
      clk1();
      wait_start(2);
      clk1();
      send_done();

      // Transmit timeout
      sb.push_back(8'hC2);
      tick_pulse();
      tick_pulse();
      wait_start(6);
      clk1();
      for (int t = 0; t < 4; t++) tick_pulse();
      chk("to_busy_before", 8'(busy), 8'd1);
      chk("to_err_before", 8'(tx_err), 8'd0);
      sb.push_back(8'hC2);
      tick = 1'b1;
      clk1();
      tick = 1'b0;
      chk("to_busy_after", 8'(busy), 8'd0);
      chk("to_err_set", 8'(tx_err), 8'd1);
      clk1();
      wait_start(4);
      clk1();
      send_done();
      chk("to_err_sticky", 8'(tx_err), 8'd1);

      // Receive path and watchdog
      auto_per = 1'b1;
      rx_valid = 1'b1; rx_data = 8'h8A;
      clk1();
      rx_valid = 1'b0;
      chk("rx_link_up", 8'(link_up), 8'd1);
      chk("rx_sensor", 8'(sensor), 8'h0A);
      rx_valid = 1'b1; rx_data = 8'h0F;
      clk1();
      rx_err = 1'b1; rx_data = 8'h8F;
      clk1();
      rx_valid = 1'b0; rx_err = 1'b0;
      chk("rx_bad_cnt2", bad_cnt, 8'd2);
      chk("rx_sensor_kept", 8'(sensor), 8'h0A);
      chk("rx_link_kept", 8'(link_up), 8'd1);
      for (int t = 0; t < 99; t++) tick_pulse();
      chk("wd_not_yet", 8'(link_up), 8'd1);
      tick_pulse();
      chk("wd_link_down", 8'(link_up), 8'd0);
      chk("wd_sensor_zero", 8'(sensor), 8'h00);

      // Good frame on the expiry cycle, then saturation of bad_cnt
      rx_valid = 1'b1; rx_data = 8'h85;
      clk1();
      rx_valid = 1'b0;
      for (int t = 0; t < 99; t++) tick_pulse();
      tick = 1'b1; rx_valid = 1'b1; rx_data = 8'h83;
      clk1();
      tick = 1'b0; rx_valid = 1'b0;
      chk("wd_race_link", 8'(link_up), 8'd1);
      chk("wd_race_sensor", 8'(sensor), 8'h03);
      rx_valid = 1'b1; rx_data = 8'h00;
      repeat (300) clk1();
      rx_valid = 1'b0;
      clk1();
      chk("bad_cnt_sat", bad_cnt, 8'hFF);
      chk("sat_sensor_kept", 8'(sensor), 8'h03);

      // Reset while waiting for completion
      auto_per = 1'b0;
      rst = 1'b1;
      clk1();
      rst = 1'b0;
      sb.push_back(8'hC2);
      tick_pulse();
      tick_pulse();
      wait_start(6);
      clk1();
      chk("pre_rst_busy", 8'(busy), 8'd1);
      rst = 1'b1;
      clk1();
      chk_all_zero("midrst");
      rst = 1'b0;
      tx_done = 1'b1;
      clk1();
      tx_done = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk("post_rst_idle", 8'(busy), 8'd0);
         clk1();
      end
      chk("post_rst_txerr", 8'(tx_err), 8'd0);
      chk("sb_drained", 8'(sb.size()), 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_link_sched.md
Name: uart_link_sched

Overview:
- Sequences the shared UART transmitter and supervises the receive side of the host link.
- Transmit side: a periodic drive-command frame and a one-shot request port share the single transmitter under fair arbitration.
- Receive side: validates incoming frames, latches the 4-bit sensor word and runs a link-alive watchdog.
- Sits between the control logic and the UART tx/rx engines. All ports are in the clk domain; tick is a 1 kHz single-cycle strobe from the divider.

Parameters:
PERIOD_MS, 2, ticks between periodic command frames (>=1)
TX_TIMEOUT_MS, 5, ticks allowed in WAIT_DONE before abort (>=1)
RX_TIMEOUT_MS, 100, ticks without a good frame before link_up drops (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick  in  1  1 kHz enable strobe, one clk cycle wide
cmd_data  in  8  current drive command; bits[6:0] used
req_valid  in  1  one-shot frame request
req_data  in  8  one-shot frame payload, sent unmodified
req_ready  out  1  one-shot request accepted this cycle
tx_data  out  8  byte to transmitter
tx_start  out  1  one-cycle start pulse to transmitter
tx_done  in  1  one-cycle completion pulse from transmitter
busy  out  1  high while a frame is in flight
tx_err  out  1  sticky: a frame timed out
rx_data  in  8  received byte
rx_valid  in  1  one-cycle received-byte strobe
rx_err  in  1  framing error qualifier for rx_valid
link_up  out  1  good frame seen within RX_TIMEOUT_MS
sensor  out  4  latched sensor bits
bad_cnt  out  8  saturating count of rejected frames

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0; per_pend=0; last_grant=PER, so the first contention goes to the one-shot port.
- Reset mid-frame aborts WAIT_DONE. No tx_start is reissued, and a later tx_done is ignored.
- Period counter:
  - Increments on tick; on reaching PERIOD_MS-1 it wraps to 0 and sets per_pend.
  - A set and a grant-clear in the same cycle: set wins, so per_pend stays 1.
  - An expiry while per_pend is already 1 is dropped (no queueing).
- FSM: IDLE -> LOAD -> WAIT_DONE -> IDLE.
- IDLE arbitration:
  - Candidates are per_pend and req_valid.
  - If both are pending, grant the source not equal to last_grant; otherwise grant the single pending source.
  - req_ready = (state==IDLE) && req_valid && one-shot granted. This is combinational and allowed to depend on req_valid.
  - Grant registers tx_data: PER -> {1'b1, cmd_data[6:0]} sampled in the grant cycle; REQ -> req_data.
  - Grant updates last_grant, clears per_pend if PER was granted, and moves to LOAD.
- LOAD: tx_start=1 for exactly this cycle; busy=1; go to WAIT_DONE and clear the timeout counter.
- WAIT_DONE:
  - busy=1; the timeout counter increments on tick.
  - tx_done -> IDLE.
  - Counter reaching TX_TIMEOUT_MS -> set tx_err, go to IDLE.
  - tx_done and timeout in the same cycle: done wins, no error.
- Latency: grant cycle N, tx_start at N+1, earliest next grant at the cycle after tx_done.
- tx_done outside WAIT_DONE is ignored.
- tx_data holds its value until the next grant.
- tx_err clears only on rst.
- Receive path, evaluated every cycle on rx_valid:
  - rx_err=0 and rx_data[7]=1 (good frame): sensor <= rx_data[3:0]; link_up <= 1; watchdog <= 0.
  - Otherwise (rx_err=1 or bit7=0): bad_cnt += 1, saturating at 255; sensor and link_up unchanged.
- Watchdog:
  - Increments on tick, saturating at RX_TIMEOUT_MS.
  - On reaching RX_TIMEOUT_MS: link_up <= 0 and sensor <= 0 (safe stop).
  - A good frame in the same cycle as expiry: the frame wins.
- Receive and transmit paths are fully independent. Simultaneous rx_valid and tx activity require no interaction.

Test Plan:
- Reset, PERIOD_MS=2, cmd_data=8'h05, tx_done returned 3 cycles after tx_start -> tx_start every 2 ticks with tx_data=8'h85, busy high from LOAD through the tx_done cycle, req_ready=0 throughout.
- per_pend and req_valid with req_data=8'h3C asserted together three times back-to-back -> grant order REQ, PER, REQ. req_ready pulses only on REQ grants; tx_data alternates 8'h3C / {1,cmd[6:0]}.
- tx_done never returned, TX_TIMEOUT_MS=5 -> FSM returns to IDLE on the 5th tick after LOAD, tx_err=1 and stays 1. The next frame still starts normally.
- rx_valid with rx_data=8'h8A -> link_up=1, sensor=4'hA. Then rx_data=8'h0F and one rx_err=1 byte -> bad_cnt=2, sensor stays 4'hA. After 100 ticks with no good frame -> link_up=0, sensor=0.
- Good frame arriving on the exact watchdog-expiry cycle -> link_up stays 1. Then 300 bad frames -> bad_cnt saturates at 255.
- rst asserted in WAIT_DONE, then tx_done pulse after release -> outputs all 0, no tx_start, FSM stays IDLE until a new grant.
